dmem_wait_responder: RTL and testbench

- Data-memory responder on the far end of the pipeline's memory-stage port (MemWrite/DataAdr/WriteData).
- Services word reads and byte-strobed writes with a parameterised wait-state latency, and stalls the pipeline through the hazard unit while busy.
- Also acts as the hardware completion monitor: raises sticky done/fail flags when the program writes to the designated result address.
- Lets the pipeline run against realistic non-single-cycle memory.

---
 rtl/mem_pkg.sv | 19 +
 rtl/dmem_bytewise_ram.sv | 50 +++++
 rtl/dmem_wait_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_wait_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state data-memory responder.
//   state_e            : responder FSM states
//   WORD_W / STRB_W    : data word width and byte-strobe width
//   DEFAULT_DONE_*     : default completion-monitor address and success value
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [31:0] DEFAULT_DONE_ADDR = 32'd100;
    localparam logic [31:0] DEFAULT_DONE_DATA = 32'd25;

endpackage

// File: rtl/dmem_bytewise_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
//   clk_i    : clock, rising edge
//   rst_ni   : async active-low reset (clears only the read register, not the array)
//   en_i     : access enable for this cycle
//   we_i     : 1 = write the strobed bytes, 0 = read the word into rdata_o
//   addr_i   : word index
//   wdata_i  : write data
//   wstrb_i  : byte enables, bit i selects byte i
//   rdata_o  : registered read data; holds its value across writes and idle cycles
module dmem_bytewise_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wstrb_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with programmable wait states and a completion monitor.
// Accepts one request in IDLE, spends WAIT_CYCLES cycles in BUSY, performs the
// access on the last BUSY edge and pulses rd_valid for one RESP cycle.
//   clk        : clock, rising edge
//   reset      : async active-low reset
//   req_valid  : access request, held stable while stall=1
//   req_write  : 1 = write, 0 = read
//   req_addr   : byte address
//   req_wdata  : write data
//   req_wstrb  : byte enables
//   stall      : combinational pipeline freeze
//   rd_valid   : one-cycle response pulse
//   rd_data    : read data, valid with rd_valid (0 for writes and out-of-range reads)
//   addr_err   : sticky misaligned / out-of-range flag
//   sim_done   : sticky, DONE_DATA written to DONE_ADDR
//   sim_fail   : sticky, other data written to DONE_ADDR
module dmem_wait_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] DONE_ADDR   = DEFAULT_DONE_ADDR,
    parameter logic [31:0] DONE_DATA   = DEFAULT_DONE_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              stall,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic              addr_err,
    output logic              sim_done,
    output logic              sim_fail
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT   = 4'(WAIT_CYCLES - 1);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              write_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              rd_valid_q;
    logic              rd_zero_q;
    logic              addr_err_q;
    logic              sim_done_q;
    logic              sim_fail_q;

    logic              access;
    logic              in_range;
    logic [WORD_W-1:0] ram_rdata;

    // The access happens on the edge that leaves BUSY.
    assign access   = (state_q == StBusy) && (cnt_q == 4'd0);
    assign in_range = addr_q < ADDR_LIMIT;

    dmem_bytewise_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (access && in_range),
        .we_i    (write_q),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
            addr_err_q <= 1'b0;
            sim_done_q <= 1'b0;
            sim_fail_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    rd_valid_q <= 1'b0;
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        cnt_q   <= CNT_INIT;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q    <= StResp;
                        rd_valid_q <= 1'b1;
                        // Writes and dropped reads respond with zero data.
                        rd_zero_q  <= write_q || !in_range;
                        if ((addr_q[1:0] != 2'b00) || !in_range) begin
                            addr_err_q <= 1'b1;
                        end
                        if (write_q && (addr_q == DONE_ADDR)) begin
                            if (wdata_q == DONE_DATA) begin
                                sim_done_q <= 1'b1;
                            end else begin
                                sim_fail_q <= 1'b1;
                            end
                        end
                    end
                end
                StResp: begin
                    rd_valid_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    rd_valid_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign stall    = req_valid && (state_q != StResp);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_zero_q ? '0 : ram_rdata;
    assign addr_err = addr_err_q;
    assign sim_done = sim_done_q;
    assign sim_fail = sim_fail_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder (DEPTH=64, WAIT_CYCLES=2, DONE at 100/25).
module tb_dmem_wait_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        addr_err;
    logic        sim_done;
    logic        sim_fail;

    int n_assert = 0;
    int n_fail   = 0;

    dmem_wait_responder #(
        .DEPTH       (64),
        .WAIT_CYCLES (2),
        .DONE_ADDR   (32'd100),
        .DONE_DATA   (32'd25)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .stall     (stall),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .addr_err  (addr_err),
        .sim_done  (sim_done),
        .sim_fail  (sim_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request right after a rising edge, counts stall cycles at the
    // falling edges until rd_valid, then withdraws the request after that edge.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdata,
                          output int stalls, output logic got, output logic stall_resp);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        stalls     = 0;
        got        = 1'b0;
        rdata      = 32'hxxxx_xxxx;
        stall_resp = 1'bx;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                got        = 1'b1;
                rdata      = rd_data;
                stall_resp = stall;
                break;
            end
            if (stall === 1'b1) stalls++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    logic [31:0] rdata;
    int          stalls;
    logic        got;
    logic        stall_resp;

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;

        // Reset state
        @(negedge clk);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_sim_done", 32'(sim_done), 32'd0);
        check("rst_sim_fail", 32'(sim_fail), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        #12;
        reset = 1'b1;  // released at 22 ns
        @(posedge clk);
        #1;

        // Test 1: write 7 to 96
        access(1'b1, 32'd96, 32'h0000_0007, 4'b1111, rdata, stalls, got, stall_resp);
        check("t1_got_resp", 32'(got), 32'd1);
        check("t1_stall_cycles", 32'(stalls), 32'd3);
        check("t1_wr_rdata_zero", rdata, 32'd0);
        check("t1_sim_done", 32'(sim_done), 32'd0);
        check("t1_sim_fail", 32'(sim_fail), 32'd0);
        check("t1_rd_valid_drop", 32'(rd_valid), 32'd0);

        // Test 2: read back 96
        access(1'b0, 32'd96, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t2_got_resp", 32'(got), 32'd1);
        check("t2_rdata", rdata, 32'h0000_0007);
        check("t2_stall_resp_low", 32'(stall_resp), 32'd0);
        check("t2_stall_cycles", 32'(stalls), 32'd3);

        // Test 3: full write then byte-0 overwrite, then no-op strobe
        access(1'b1, 32'd0, 32'hAABB_CCDD, 4'b1111, rdata, stalls, got, stall_resp);
        access(1'b1, 32'd0, 32'h0000_0011, 4'b0001, rdata, stalls, got, stall_resp);
        access(1'b0, 32'd0, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t3_byte_merge", rdata, 32'hAABB_CC11);
        access(1'b1, 32'd0, 32'hFFFF_FFFF, 4'b0000, rdata, stalls, got, stall_resp);
        check("t3_noop_completes", 32'(got), 32'd1);
        access(1'b0, 32'd0, 32'h0, 4'b1111, rdata, stalls, got, stall_resp);
        check("t3_noop_unchanged", rdata, 32'hAABB_CC11);
        access(1'b1, 32'd8, 32'h1234_5678, 4'b1010, rdata, stalls, got, stall_resp);
        access(1'b0, 32'd8, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t3_upper_strobes", rdata & 32'hFF00_FF00, 32'h1200_5600);
        check("t3_no_addr_err", 32'(addr_err), 32'd0);
        check("t3_monitor_quiet", {30'd0, sim_done, sim_fail}, 32'd0);

        // Test 4: completion monitor
        access(1'b1, 32'd100, 32'd25, 4'b1111, rdata, stalls, got, stall_resp);
        check("t4_sim_done", 32'(sim_done), 32'd1);
        check("t4_sim_fail", 32'(sim_fail), 32'd0);
        access(1'b1, 32'd100, 32'd26, 4'b0001, rdata, stalls, got, stall_resp);
        check("t4_sim_fail_set", 32'(sim_fail), 32'd1);
        check("t4_sim_done_held", 32'(sim_done), 32'd1);

        // Test 5: address errors
        access(1'b0, 32'h0000_0002, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t5_misaligned_rdata", rdata, 32'hAABB_CC11);
        check("t5_misaligned_err", 32'(addr_err), 32'd1);
        access(1'b0, 32'h0000_0102, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t5_0x102_rdata", rdata, 32'd0);
        access(1'b0, 32'd256, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t5_oor_read_zero", rdata, 32'd0);
        check("t5_oor_read_resp", 32'(got), 32'd1);
        access(1'b1, 32'd256, 32'hDEAD_BEEF, 4'b1111, rdata, stalls, got, stall_resp);
        access(1'b0, 32'd0, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t5_oor_write_w0", rdata, 32'hAABB_CC11);
        access(1'b0, 32'd96, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t5_oor_write_w24", rdata, 32'h0000_0007);
        access(1'b0, 32'd100, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t5_word25", rdata, 32'd26);

        // Test 6: reset during BUSY aborts a write of 25 to 100
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'd100;
        req_wdata = 32'd25;
        req_wstrb = 4'b1111;
        @(posedge clk);
        #2;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("t6_stall_low", 32'(stall), 32'd0);
        check("t6_rd_valid_low", 32'(rd_valid), 32'd0);
        check("t6_flags_cleared", {29'd0, addr_err, sim_done, sim_fail}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t6_no_pulse", 32'(rd_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 32'd100, 32'h0, 4'b0000, rdata, stalls, got, stall_resp);
        check("t6_word25_kept", rdata, 32'd26);
        check("t6_sim_done", 32'(sim_done), 32'd0);
        check("t6_sim_fail", 32'(sim_fail), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
